// File: rtl/yrv_uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : yrv_uart_pkg
// Purpose  : Shared UART frame constants and transmitter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package yrv_uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Width of a counter spanning 0..clks-1; never narrower than one bit.
  function automatic int baud_width(input int clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Synchronous power-of-two FIFO with registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_PTR_W-1:0] wptr_q;
  logic [c_PTR_W-1:0] rptr_q;
  logic [c_CNT_W-1:0] count_q;
  logic               w_push;
  logic               w_pop;

  assign full_o  = (count_q == c_CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Overflow and underflow requests are dropped so the contents stay intact.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) begin
        wptr_q <= wptr_q + c_PTR_W'(1);
      end
      if (w_pop) begin
        rptr_q <= rptr_q + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_CNT_W'(1);
        2'b01:   count_q <= count_q - c_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ser.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ser
// Purpose  : FIFO-buffered 8N1 UART transmitter with registered serial output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ser
  import yrv_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          ser_txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int                  c_BAUD_W    = baud_width(CLKS_PER_BIT);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                  c_BIT_W     = $clog2(DATA_BITS);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);

  tx_state_t              state_q, state_d;
  logic [c_BAUD_W-1:0]    baud_q, baud_d;
  logic [c_BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   txd_q, txd_d;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_baud_last;
  logic [DATA_BITS-1:0]   w_head;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  assign w_push = tx_valid & ~w_full & ~reset;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .wdata_i (tx_data),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign w_baud_last = (baud_q == c_BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    w_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          shreg_d = w_head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_last) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + c_BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (w_baud_last) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == c_BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + c_BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + c_BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (w_baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so frames stay contiguous.
          if (!w_empty) begin
            w_pop   = 1'b1;
            shreg_d = w_head;
            bit_d   = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + c_BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level is decoded from the next state so the output flop lines up with it.
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shreg_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  assign ser_txd    = txd_q;
  assign tx_ready   = ~w_full;
  assign fifo_count = w_count;
  assign busy       = (state_q != ST_IDLE) || (w_count != '0);
  assign tx_done    = (state_q == ST_STOP) && w_baud_last && !reset;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ser.sv
`default_nettype none
// Bench for uart_tx_ser: an 80-clock and a 2-clock instance, each watched by a
// mid-bit receiver that pops the expected byte queue at every start bit.
module tb_uart_tx_ser;
  import yrv_uart_pkg::*;

  localparam int CPB_A = 80;
  localparam int CPB_B = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] dat_a = 8'h00, dat_b = 8'h00;
  logic       vld_a = 1'b0, vld_b = 1'b0;
  logic       rdy_a, txd_a, busy_a, done_a;
  logic       rdy_b, txd_b, busy_b, done_b;
  logic [2:0] cnt_a, cnt_b;

  uart_tx_ser #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .reset(reset), .tx_data(dat_a), .tx_valid(vld_a), .tx_ready(rdy_a),
    .ser_txd(txd_a), .busy(busy_a), .tx_done(done_a), .fifo_count(cnt_a));

  uart_tx_ser #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .reset(reset), .tx_data(dat_b), .tx_valid(vld_b), .tx_ready(rdy_b),
    .ser_txd(txd_b), .busy(busy_b), .tx_done(done_b), .fifo_count(cnt_b));

  logic [1:0] txd_w, done_w, rdy_w, busy_w;
  assign txd_w  = {txd_b, txd_a};
  assign done_w = {done_b, done_a};
  assign rdy_w  = {rdy_b, rdy_a};
  assign busy_w = {busy_b, busy_a};

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  bit         mon_act[2];
  int         stray[2];
  int         dcount[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  function automatic bit pop_exp(input int d, output logic [7:0] b);
    b = 8'h00;
    if (d == 0) begin
      if (q_a.size() == 0) return 1'b0;
      b = q_a.pop_front();
    end else begin
      if (q_b.size() == 0) return 1'b0;
      b = q_b.pop_front();
    end
    return 1'b1;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q_a.size() : q_b.size();
  endfunction

  // Receiver model: checks every cycle of the frame against the ideal waveform,
  // decodes data at mid-bit and expects tx_done only on the final stop cycle.
  task automatic monitor(input int d);
    int         cpb;
    int         i;
    int         bad_i;
    bit         done_bad;
    bit         have;
    logic [7:0] exp;
    logic [7:0] rx;
    cpb = (d == 0) ? CPB_A : CPB_B;
    i = 0; bad_i = -1; done_bad = 1'b0; have = 1'b0; exp = 8'h00; rx = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_act[d] = 1'b0;
        continue;
      end
      if (done_w[d]) dcount[d]++;
      if (!mon_act[d]) begin
        if (done_w[d]) stray[d]++;
        if (txd_w[d] === 1'b0) begin
          mon_act[d] = 1'b1;
          i = 0; bad_i = -1; done_bad = 1'b0; rx = 8'h00;
          have = pop_exp(d, exp);
        end
      end
      if (mon_act[d]) begin
        if (txd_w[d] !== frame_bit(exp, i / cpb) && bad_i < 0) bad_i = i;
        if (done_w[d] !== (i == 10 * cpb - 1)) done_bad = 1'b1;
        if ((i % cpb) == cpb / 2 && i / cpb >= 1 && i / cpb <= 8) rx[i/cpb-1] = txd_w[d];
        i++;
        if (i == 10 * cpb) begin
          mon_act[d] = 1'b0;
          chk("frame_expected", {31'd0, have}, 32'd1);
          chk("rx_byte", {24'd0, rx}, {24'd0, exp});
          chk("wave_first_bad_cycle", bad_i, -1);
          chk("done_position", {31'd0, done_bad}, 32'd0);
        end
      end
    end
  endtask

  task automatic send(input int d, input logic [7:0] b, output int waited);
    bit acc;
    int t;
    acc = 1'b0; t = 0;
    if (d == 0) begin dat_a = b; vld_a = 1'b1; end
    else        begin dat_b = b; vld_b = 1'b1; end
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = rdy_w[d];
      @(posedge clk);
      #1;
      t++;
    end
    if (d == 0) vld_a = 1'b0; else vld_b = 1'b0;
    if (acc) begin
      if (d == 0) q_a.push_back(b); else q_b.push_back(b);
    end else begin
      chk("accept_timeout", 32'd0, 32'd1);
    end
    waited = t;
  endtask

  task automatic wait_idle(input int d);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy_w[d] || mon_act[d] || qsize(d) != 0) && t < 30000);
    chk("idle_reached", {31'd0, (t < 30000)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w, k, t, t1, t2, d0;
    logic [7:0] b;
    fork
      monitor(0);
      monitor(1);
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'd0, txd_a}, 32'd1);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_ready", {31'd0, rdy_a}, 32'd1);
    chk("rst_count", {29'd0, cnt_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_txd_b", {31'd0, txd_b}, 32'd1);
    chk("rst_count_b", {29'd0, cnt_b}, 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 0x55 frame and first-byte latency
    send(0, 8'h55, w);
    chk("lat_txd_idle", {31'd0, txd_a}, 32'd1);
    chk("lat_count", {29'd0, cnt_a}, 32'd1);
    chk("lat_busy", {31'd0, busy_a}, 32'd1);
    @(posedge clk);
    #1;
    chk("lat_txd_start", {31'd0, txd_a}, 32'd0);
    chk("lat_count_popped", {29'd0, cnt_a}, 32'd0);
    wait_idle(0);

    // 0xA5, 0x3C back-to-back: done spacing and busy fall
    send(0, 8'hA5, w);
    send(0, 8'h3C, w);
    k = 0; t = 0; t1 = 0; t2 = 0;
    while (k < 2 && t < 4000) begin
      @(negedge clk);
      t++;
      if (done_a) begin
        k++;
        if (k == 1) t1 = t; else t2 = t;
      end
    end
    chk("two_done_pulses", k, 2);
    chk("done_spacing", t2 - t1, 800);
    chk("busy_at_done2", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    chk("busy_after_done2", {31'd0, busy_a}, 32'd0);
    wait_idle(0);

    // FIFO fill with tx_valid held: six bytes
    send(0, 8'h01, w);
    chk("fill_count1", {29'd0, cnt_a}, 32'd1);
    send(0, 8'h02, w);
    chk("fill_push_pop", {29'd0, cnt_a}, 32'd1);
    send(0, 8'h03, w);
    send(0, 8'h04, w);
    send(0, 8'h05, w);
    chk("fill_count4", {29'd0, cnt_a}, 32'd4);
    chk("fill_not_ready", {31'd0, rdy_a}, 32'd0);
    send(0, 8'h06, w);
    chk("fill_wait_for_pop", w, 798);
    chk("fill_count_again", {29'd0, cnt_a}, 32'd4);
    wait_idle(0);

    // Reset 300 cycles into a 0xFF frame with two bytes queued
    d0 = dcount[0];
    send(0, 8'hFF, w);
    send(0, 8'h11, w);
    send(0, 8'h22, w);
    repeat (298) @(posedge clk);
    #1;
    reset = 1'b1;
    vld_a = 1'b1;
    dat_a = 8'h99;
    q_a.delete();
    @(posedge clk);
    #1;
    chk("abort_txd", {31'd0, txd_a}, 32'd1);
    chk("abort_count", {29'd0, cnt_a}, 32'd0);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    chk("abort_ready", {31'd0, rdy_a}, 32'd1);
    chk("abort_done", {31'd0, done_a}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    vld_a = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_valid_ignored", {29'd0, cnt_a}, 32'd0);
    chk("abort_no_done", dcount[0], d0);
    send(0, 8'h3C, w);
    wait_idle(0);
    chk("after_reset_one_done", dcount[0], d0 + 1);

    // Two clocks per bit: 0x00 and 0xFF, then random traffic with gaps
    send(1, 8'h00, w);
    send(1, 8'hFF, w);
    wait_idle(1);
    for (int n = 0; n < 1000; n++) begin
      b = 8'($urandom);
      send(1, b, w);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(10, 60)) @(posedge clk);
        #1;
      end
    end
    wait_idle(1);

    chk("stray_done_a", stray[0], 0);
    chk("stray_done_b", stray[1], 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
